mda_vram_arbiter: RTL and testbench

Shares the single-port 4000-byte MDA text VRAM between the display fetch path and a host (CPU-bus) port, clocked by `pixclk`. It sits behind the 720x350 timing generator and consumes its `enable`, `xpix` and `ypix` outputs. It prefetches each 9x14 character cell's code and attribute one cell ahead for the glyph renderer. Host accesses are granted in every VRAM cycle the display does not need.

---
 rtl/mda_vram_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mda_vram_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter
// Shares the single-port MDA text VRAM between the display fetch path and a
// host port. The display prefetches each 9x14 cell's char/attr one cell ahead;
// the host gets every VRAM cycle the display does not need.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT      | after reset: host-only, no display fetch until enable first falls
// ACTIVE    | active video: per-cell fetch at ph=0/1, host in the other slots
// PF_CHAR   | blanking prefetch: read char of cell 0 of the next line
// PF_ATTR   | blanking prefetch: read attr of cell 0 of the next line
// PF_LOAD   | present cell 0 on char_code/attr, cell_valid set
// BLANK     | blanking, host-only; leave on enable rising

module mda_vram_arbiter #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int CELL_W = 9,
    parameter int CELL_H = 14,
    parameter int VA_END = 349,
    parameter int AW     = 12
) (
    input  logic          pixclk,
    input  logic          rst,
    input  logic          enable,
    input  logic [9:0]    xpix,
    input  logic [8:0]    ypix,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic          host_ack,
    output logic [7:0]    host_rdata,
    output logic [AW-1:0] vram_addr,
    output logic          vram_we,
    output logic [7:0]    vram_wdata,
    input  logic [7:0]    vram_rdata,
    output logic [7:0]    char_code,
    output logic [7:0]    attr,
    output logic [3:0]    glyph_row,
    output logic          cell_valid
);

    localparam int              TRW       = $clog2(ROWS);
    localparam logic [3:0]      PH_LAST   = 4'(CELL_W - 1);
    localparam logic [6:0]      COL_LAST  = 7'(COLS - 1);
    localparam logic [3:0]      GROW_LAST = 4'(CELL_H - 1);
    localparam logic [8:0]      Y_LAST    = 9'(VA_END);
    localparam logic [AW-1:0]   ROW_BYTES = AW'(2 * COLS);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_ACTIVE,
        ST_PF_CHAR,
        ST_PF_ATTR,
        ST_PF_LOAD,
        ST_BLANK
    } state_t;

    // What the read issued last cycle was for; routes vram_rdata this cycle.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CHAR,
        TAG_ATTR,
        TAG_HOST
    } tag_t;

    state_t          state, state_nxt;
    tag_t            rd_tag, tag_nxt;
    logic            line_upd;
    logic [3:0]      ph;
    logic [6:0]      col;
    logic [6:0]      col_p1;
    logic [TRW-1:0]  text_row;
    logic [AW-1:0]   line_base;
    logic [AW-1:0]   cell_addr;
    logic            act_fetch;
    logic [7:0]      nxt_char;
    logic [7:0]      nxt_attr;
    logic [7:0]      attr_fwd;
    logic            unused_xpix;

    // xpix is provided by the timing generator but sequencing runs off ph/col.
    assign unused_xpix = ^xpix;

    assign col_p1    = col + 7'd1;
    assign cell_addr = line_base + AW'({col_p1, 1'b0});
    assign act_fetch = enable && (state != ST_WAIT) && (col < COL_LAST);

    assign host_ack   = (rd_tag == TAG_HOST);
    assign host_rdata = host_ack ? vram_rdata : 8'h00;

    // The attr read lands in the same cycle PF_LOAD presents it, so forward it.
    assign attr_fwd = (rd_tag == TAG_ATTR) ? vram_rdata : nxt_attr;

    // State register.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a falling enable in WAIT or ACTIVE closes a scanline.
    always_comb begin
        state_nxt = state;
        line_upd  = 1'b0;
        case (state)
            ST_WAIT, ST_ACTIVE: begin
                if (!enable) begin
                    state_nxt = ST_PF_CHAR;
                    line_upd  = 1'b1;
                end
            end
            ST_PF_CHAR: state_nxt = ST_PF_ATTR;
            ST_PF_ATTR: state_nxt = ST_PF_LOAD;
            ST_PF_LOAD: state_nxt = ST_BLANK;
            ST_BLANK: begin
                if (enable) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // Pixel-in-cell and column counters, held at zero outside active video.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            ph  <= 4'd0;
            col <= 7'd0;
        end else if (!enable) begin
            ph  <= 4'd0;
            col <= 7'd0;
        end else if (ph == PH_LAST) begin
            ph  <= 4'd0;
            col <= (col == COL_LAST) ? 7'd0 : col + 7'd1;
        end else begin
            ph <= ph + 4'd1;
        end
    end

    // Scanline-in-row, text row and row base address, stepped once per line.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            glyph_row <= 4'd0;
            text_row  <= '0;
            line_base <= '0;
        end else if (line_upd) begin
            if (ypix == Y_LAST) begin
                glyph_row <= 4'd0;
                text_row  <= '0;
                line_base <= '0;
            end else if (glyph_row == GROW_LAST) begin
                glyph_row <= 4'd0;
                text_row  <= text_row + TRW'(1);
                line_base <= line_base + ROW_BYTES;
            end else begin
                glyph_row <= glyph_row + 4'd1;
            end
        end
    end

    // VRAM port mux: prefetch, then active fetch, then host; host never
    // preempts the display and is not granted in its own ack cycle or in reset.
    always_comb begin
        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = 8'h00;
        tag_nxt    = TAG_NONE;
        if (state == ST_PF_CHAR) begin
            vram_addr = line_base;
            tag_nxt   = TAG_CHAR;
        end else if (state == ST_PF_ATTR) begin
            vram_addr = line_base + AW'(1);
            tag_nxt   = TAG_ATTR;
        end else if (act_fetch && (ph == 4'd0)) begin
            vram_addr = cell_addr;
            tag_nxt   = TAG_CHAR;
        end else if (act_fetch && (ph == 4'd1)) begin
            vram_addr = cell_addr + AW'(1);
            tag_nxt   = TAG_ATTR;
        end else if (host_req && !host_ack && !rst) begin
            vram_addr  = host_addr;
            vram_we    = host_we;
            vram_wdata = host_wdata;
            tag_nxt    = TAG_HOST;
        end
    end

    // Read-return tag; reset drops any outstanding host access.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            rd_tag <= TAG_NONE;
        end else begin
            rd_tag <= tag_nxt;
        end
    end

    // Next-cell holding registers filled from returned display reads.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            nxt_char <= 8'h00;
            nxt_attr <= 8'h00;
        end else begin
            if (rd_tag == TAG_CHAR) begin
                nxt_char <= vram_rdata;
            end
            if (rd_tag == TAG_ATTR) begin
                nxt_attr <= vram_rdata;
            end
        end
    end

    // Present the prefetched cell at PF_LOAD and at every cell boundary.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            char_code  <= 8'h00;
            attr       <= 8'h00;
            cell_valid <= 1'b0;
        end else if (state == ST_PF_LOAD) begin
            char_code  <= nxt_char;
            attr       <= attr_fwd;
            cell_valid <= 1'b1;
        end else if (enable && (state != ST_WAIT) && (ph == PH_LAST)) begin
            char_code <= nxt_char;
            attr      <= attr_fwd;
        end
    end

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Testbench for mda_vram_arbiter: directed scanlines and host accesses against
// a 1-cycle-latency VRAM model; expected values are queued when stimulus is
// issued and compared by a negedge monitor.

module tb_mda_vram_arbiter;

    localparam int AW = 12;

    localparam int S_ADDR   = 0;
    localparam int S_WE     = 1;
    localparam int S_CHAR   = 2;
    localparam int S_ATTR   = 3;
    localparam int S_GROW   = 4;
    localparam int S_CVALID = 5;
    localparam int S_ACK    = 6;

    logic          pixclk = 1'b0;
    logic          rst;
    logic          enable;
    logic [9:0]    xpix;
    logic [8:0]    ypix;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_ack;
    logic [7:0]    host_rdata;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [7:0]    vram_wdata;
    logic [7:0]    vram_rdata;
    logic [7:0]    char_code;
    logic [7:0]    attr;
    logic [3:0]    glyph_row;
    logic          cell_valid;

    logic [7:0] mem [0:4095];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        int sig;
        int exp;
    } chk_t;

    typedef struct {
        int         cyc;
        logic       is_wr;
        logic [7:0] rdata;
    } hexp_t;

    chk_t  chk_q[$];
    hexp_t host_q[$];

    mda_vram_arbiter #(
        .COLS(80), .ROWS(25), .CELL_W(9), .CELL_H(14), .VA_END(349), .AW(AW)
    ) dut (
        .pixclk     (pixclk),
        .rst        (rst),
        .enable     (enable),
        .xpix       (xpix),
        .ypix       (ypix),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .char_code  (char_code),
        .attr       (attr),
        .glyph_row  (glyph_row),
        .cell_valid (cell_valid)
    );

    always #5 pixclk = ~pixclk;

    always @(posedge pixclk) cyc <= cyc + 1;

    // Single-port VRAM, read data one cycle after the address.
    always @(posedge pixclk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    function automatic int actual(input int sig);
        case (sig)
            S_ADDR:   return int'(vram_addr);
            S_WE:     return int'(vram_we);
            S_CHAR:   return int'(char_code);
            S_ATTR:   return int'(attr);
            S_GROW:   return int'(glyph_row);
            S_CVALID: return int'(cell_valid);
            default:  return int'(host_ack);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_ADDR:   return "vram_addr";
            S_WE:     return "vram_we";
            S_CHAR:   return "char_code";
            S_ATTR:   return "attr";
            S_GROW:   return "glyph_row";
            S_CVALID: return "cell_valid";
            default:  return "host_ack";
        endcase
    endfunction

    // Monitor: scheduled output checks, plus every host_ack against the host queue.
    always @(negedge pixclk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                n_tests++;
                if (actual(chk_q[i].sig) != chk_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got 0x%0h, required 0x%0h",
                             sig_name(chk_q[i].sig), cyc, actual(chk_q[i].sig), chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
        if (host_ack) begin
            n_tests++;
            if (host_q.size() == 0) begin
                n_fail++;
                $display("FAIL host_ack cycle %0d: got unexpected ack, required none", cyc);
            end else begin
                hexp_t h;
                h = host_q.pop_front();
                if (h.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL host_ack_time: got ack at cycle %0d, required cycle %0d", cyc, h.cyc);
                end else if (!h.is_wr && host_rdata != h.rdata) begin
                    n_fail++;
                    $display("FAIL host_rdata cycle %0d: got 0x%0h, required 0x%0h", cyc, host_rdata, h.rdata);
                end
            end
        end
    end

    task automatic sched(input int c, input int s, input int e);
        chk_t k;
        k.cyc = c;
        k.sig = s;
        k.exp = e;
        chk_q.push_back(k);
    endtask

    task automatic host_exp(input int c, input logic wr, input logic [7:0] d);
        hexp_t h;
        h.cyc   = c;
        h.is_wr = wr;
        h.rdata = d;
        host_q.push_back(h);
    endtask

    task automatic tick;
        @(posedge pixclk);
        #1;
    endtask

    // One host access, held until ack (bounded); back-to-back calls keep req high.
    task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        logic acked;
        acked      = 1'b0;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_req   = 1'b1;
        for (int i = 0; i < 12 && !acked; i++) begin
            tick;
            if (host_ack) acked = 1'b1;
        end
        host_req = 1'b0;
        if (!acked) begin
            n_tests++;
            n_fail++;
            $display("FAIL host_timeout addr 0x%0h: got no ack, required ack within 12 cycles", a);
        end
    endtask

    // One scanline: len active cycles at row y, then blank cycles.
    task automatic run_line(input int len, input int y, input int blank);
        enable = 1'b1;
        ypix   = y[8:0];
        repeat (len) tick;
        enable = 1'b0;
        repeat (blank) tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, f, t, u;
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
        mem[0] = 8'h5A;

        rst        = 1'b1;
        enable     = 1'b1;
        xpix       = 10'd0;
        ypix       = 9'd0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = 8'h00;

        // Reset with enable high, then WAIT until the first falling edge.
        repeat (3) tick;
        sched(cyc, S_CVALID, 0);
        sched(cyc, S_CHAR, 0);
        sched(cyc, S_GROW, 0);
        sched(cyc, S_ACK, 0);
        sched(cyc, S_WE, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            sched(cyc, S_ADDR, 0);
        end
        tick;
        enable = 1'b0;
        f = cyc;
        sched(f,     S_GROW,   0);
        sched(f + 1, S_GROW,   1);
        sched(f + 1, S_ADDR,   0);
        sched(f + 2, S_ADDR,   1);
        sched(f + 3, S_CVALID, 0);
        sched(f + 4, S_CVALID, 1);
        sched(f + 4, S_CHAR,   8'h5A);
        sched(f + 4, S_ATTR,   8'h01);
        repeat (12) tick;

        // Full active line 1 (glyph_row 1, line_base 0).
        r = cyc;
        sched(r,       S_CHAR, 8'h5A);
        sched(r,       S_ATTR, 8'h01);
        sched(r,       S_ADDR, 2);
        sched(r + 1,   S_ADDR, 3);
        sched(r + 2,   S_ADDR, 0);
        sched(r + 9,   S_CHAR, 2);
        sched(r + 9,   S_ATTR, 3);
        sched(r + 9,   S_ADDR, 4);
        sched(r + 702, S_ADDR, 158);
        sched(r + 703, S_ADDR, 159);
        sched(r + 711, S_ADDR, 0);
        sched(r + 711, S_CHAR, 158);
        sched(r + 711, S_ATTR, 159);
        sched(r + 712, S_ADDR, 0);
        sched(r + 721, S_GROW, 2);
        sched(r + 722, S_ADDR, 1);
        run_line(720, 1, 20);

        // Line 2: host write at ph=0 of cell 5, then back-to-back reads in blanking.
        r = cyc;
        f = r + 720;
        sched(r + 45, S_ADDR, 12);
        sched(r + 46, S_ADDR, 13);
        sched(r + 46, S_WE,   0);
        sched(r + 47, S_ADDR, 12'h100);
        sched(r + 47, S_WE,   1);
        host_exp(r + 48, 1'b1, 8'h00);
        sched(f,     S_ADDR, 12'h100);
        sched(f + 1, S_GROW, 3);
        sched(f + 2, S_ADDR, 1);
        sched(f + 3, S_ADDR, 12'h0FF);
        host_exp(f + 1, 1'b0, 8'hC3);
        host_exp(f + 4, 1'b0, 8'hFF);
        host_exp(f + 6, 1'b0, 8'h07);
        host_exp(f + 8, 1'b0, 8'h9F);
        fork
            run_line(720, 2, 30);
            begin
                repeat (45) tick;
                host_access(1'b1, 12'h100, 8'hC3);
            end
            begin
                repeat (720) tick;
                host_access(1'b0, 12'h100, 8'h00);
                host_access(1'b0, 12'h0FF, 8'h00);
                host_access(1'b0, 12'h007, 8'h00);
                host_access(1'b0, 12'hF9F, 8'h00);
            end
        join

        // Short lines up to glyph_row 13, then the row wrap.
        for (int y = 3; y <= 12; y++) run_line(18, y, 10);
        r = cyc;
        f = r + 18;
        sched(f,     S_GROW, 13);
        sched(f + 1, S_GROW, 0);
        sched(f + 1, S_ADDR, 160);
        sched(f + 2, S_ADDR, 161);
        sched(f + 4, S_CHAR, 8'hA0);
        sched(f + 4, S_ATTR, 8'hA1);
        run_line(18, 13, 10);

        r = cyc;
        sched(r,     S_ADDR, 162);
        sched(r,     S_CHAR, 8'hA0);
        sched(r + 1, S_ADDR, 163);
        sched(r + 9, S_CHAR, 8'hA2);
        run_line(18, 14, 10);

        // Last active scanline: frame wrap back to row 0.
        r = cyc;
        f = r + 18;
        sched(f,     S_GROW, 1);
        sched(f + 1, S_GROW, 0);
        sched(f + 1, S_ADDR, 0);
        sched(f + 2, S_ADDR, 1);
        sched(f + 4, S_CHAR, 8'h5A);
        sched(f + 4, S_ATTR, 8'h01);
        run_line(18, 349, 10);

        // Reset lands while a host read is granted: the access is dropped.
        t = cyc;
        sched(t,     S_ACK,    0);
        sched(t,     S_CVALID, 0);
        sched(t,     S_CHAR,   0);
        sched(t,     S_ATTR,   0);
        sched(t,     S_GROW,   0);
        sched(t,     S_ADDR,   0);
        sched(t,     S_WE,     0);
        sched(t + 1, S_ACK,    0);
        sched(t + 1, S_CVALID, 0);
        host_we   = 1'b0;
        host_addr = 12'h055;
        host_req  = 1'b1;
        #3;
        rst      = 1'b1;
        host_req = 1'b0;
        enable   = 1'b1;
        ypix     = 9'd0;
        repeat (2) tick;
        rst = 1'b0;
        u = cyc;
        sched(u,     S_ADDR, 0);
        sched(u + 1, S_ADDR, 0);
        sched(u + 2, S_ADDR, 0);
        repeat (3) tick;
        sched(u + 3, S_ADDR, 12'h055);
        host_exp(u + 4, 1'b0, 8'h55);
        host_access(1'b0, 12'h055, 8'h00);

        repeat (4) tick;
        @(negedge pixclk);
        #1;
        foreach (chk_q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s cycle %0d: got no sample, required 0x%0h",
                     sig_name(chk_q[i].sig), chk_q[i].cyc, chk_q[i].exp);
        end
        foreach (host_q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL host_ack_missing: got no ack, required ack at cycle %0d", host_q[i].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
